// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select/enable of a shared 4:1 mux.
// One requester holds the mux at a time; hold time is bounded under contention.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       en,
  output logic       busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(MAX_HOLD);
  // With preemption disabled the counter still saturates instead of wrapping.
  localparam logic [CNT_W-1:0] CNT_SAT    = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : HOLD_LIM;
  localparam bit               PREEMPT_EN = (MAX_HOLD != 0);

  logic [0:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;

  logic       win_found;
  logic [1:0] win_idx;
  logic       release_w;
  logic       preempt_w;

  // First set request bit searching upward (mod 4) from ptr.
  always_comb begin
    logic [1:0] cand;
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + i[1:0];
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign release_w = ~req[sel_q];
  assign preempt_w = PREEMPT_EN && (cnt_q == HOLD_LIM) && (|(req & ~gnt_q));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win_idx;
          sel_d   = win_idx;
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      GRANT: begin
        // Release and preempt share one exit path; sel stays put while idle.
        if (release_w || preempt_w) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = sel_q + 2'd1;
          cnt_d   = '0;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign en   = (state_q == GRANT);
  assign busy = (state_q == GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: default build plus a MAX_HOLD=0 build.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, req0;
  logic [3:0] gnt, gnt0;
  logic [1:0] sel, sel0;
  logic       en, en0, busy, busy0;
  logic [3:0] mux_i;
  logic       mux_y;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .sel(sel), .en(en), .busy(busy)
  );

  mux_rr_arbiter #(.MAX_HOLD(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0),
    .gnt(gnt0), .sel(sel0), .en(en0), .busy(busy0)
  );

  // Shared 4:1 mux sitting behind the arbiter.
  assign mux_y = en & mux_i[sel];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end else begin
      $display("ok   %s @%0t: %0h", tag, $time, obs);
    end
  endtask

  task automatic check_dut(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_sel,
                           input logic e_en);
    check({tag, ".gnt"},  32'(gnt),  32'(e_gnt));
    check({tag, ".sel"},  32'(sel),  32'(e_sel));
    check({tag, ".en"},   32'(en),   32'(e_en));
    check({tag, ".busy"}, 32'(busy), 32'(e_en));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] e;
    rst_n = 1'b0;
    req   = 4'b0000;
    req0  = 4'b0000;
    mux_i = 4'b0000;

    #2;
    check_dut("rst", 4'b0000, 2'd0, 1'b0);
    check("rst0.gnt", 32'(gnt0), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_dut("idle", 4'b0000, 2'd0, 1'b0);

    // Single request from IDLE, then drop it.
    req   = 4'b0100;
    mux_i = 4'b0101;
    tick();
    check_dut("single", 4'b0100, 2'd2, 1'b1);
    check("single.mux_y", 32'(mux_y), 32'h1);
    req = 4'b0000;
    tick();
    check_dut("single_rel", 4'b0000, 2'd2, 1'b0);

    // ptr is now 3: requester 3 wins over 0, then gets preempted in favour of 0.
    req = 4'b1001;
    tick();
    check_dut("ptr3", 4'b1000, 2'd3, 1'b1);
    for (int c = 0; c < 7; c++) begin
      tick();
      check_dut("hold3", 4'b1000, 2'd3, 1'b1);
    end
    tick();
    check_dut("preempt3", 4'b0000, 2'd3, 1'b0);
    tick();
    check_dut("fair0", 4'b0001, 2'd0, 1'b1);
    req = 4'b0000;
    tick();
    check_dut("rel0", 4'b0000, 2'd0, 1'b0);

    // Asynchronous reset while granted (ptr is 1 here).
    req = 4'b1111;
    tick();
    check_dut("pre_rst", 4'b0010, 2'd1, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check_dut("async_rst", 4'b0000, 2'd0, 1'b0);
    tick();
    check_dut("in_rst", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;

    // Full contention: 0,1,2,3,0 each for 8 cycles with one idle cycle between.
    for (int g = 0; g < 5; g++) begin
      e = 4'b0001 << (g % 4);
      for (int c = 0; c < 8; c++) begin
        tick();
        check_dut("rr", e, 2'(g % 4), 1'b1);
      end
      tick();
      check_dut("rr_idle", 4'b0000, 2'(g % 4), 1'b0);
    end
    req = 4'b0000;
    tick();
    check_dut("rr_end", 4'b0000, 2'd0, 1'b0);

    // Lone requester is never preempted.
    req = 4'b0010;
    for (int c = 0; c < 40; c++) begin
      tick();
      check_dut("lone", 4'b0010, 2'd1, 1'b1);
    end
    req = 4'b0000;
    tick();
    check_dut("lone_rel", 4'b0000, 2'd1, 1'b0);

    // MAX_HOLD=0 build: no preemption at all.
    req0 = 4'b0011;
    for (int c = 0; c < 40; c++) begin
      tick();
      check("nohold.gnt", 32'(gnt0), 32'h1);
      check("nohold.en",  32'(en0),  32'h1);
    end
    req0 = 4'b0010;
    tick();
    check("nohold_rel.gnt", 32'(gnt0), 32'h0);
    check("nohold_rel.en",  32'(en0),  32'h0);
    tick();
    check("nohold_next.gnt", 32'(gnt0), 32'h2);
    check("nohold_next.sel", 32'(sel0), 32'h1);
    req0 = 4'b0000;
    tick();
    check("nohold_end.gnt", 32'(gnt0), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
